fetch_stage: RTL and testbench

- Instruction-fetch stage of the segmented processor; sits directly upstream of the IF/ID pipeline register and decode.
- Owns the PC and issues single-outstanding word requests to instruction memory. Response latency is variable.
- Buffers fetched words in a small queue and presents {instruction, PC+4} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding any in-flight response.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input,
// and the valid/ready handshake toward decode.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;

    // The fetch stage itself.
    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc4,
        input  imem_valid, imem_data, redirect, redirect_pc, id_ready
    );

    // Instruction memory, later stages and decode, seen from outside.
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc4,
        output imem_valid, imem_data, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight,
// queues {instr, pc4} for decode and flushes on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q;
    logic [31:0]     pc_req_q;
    logic            imem_req_q;
    logic [31:0]     imem_addr_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_post;
    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc4_mem   [DEPTH];

    logic pop, resp, push, issue, has_head;

    assign has_head = (count_q != '0);

    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise an uncovered path silently infers a latch.
    always_comb begin
        pop        = has_head && bus.id_ready && !bus.redirect;
        resp       = (state_q == WAIT) && bus.imem_valid;
        push       = resp && !bus.redirect;
        count_post = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        issue      = !bus.redirect && ((state_q == IDLE) || resp)
                     && (count_post < CW'(DEPTH));
        state_d    = state_q;
        case (state_q)
            IDLE: if (issue) state_d = WAIT;
            WAIT: begin
                if (bus.redirect)
                    state_d = bus.imem_valid ? IDLE : DROP;
                else if (bus.imem_valid)
                    state_d = issue ? WAIT : IDLE;
            end
            // The stale response is consumed here even if another redirect
            // lands on the same cycle; waiting longer would never end.
            DROP: if (bus.imem_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            pc_req_q    <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= issue;
            if (issue) begin
                imem_addr_q <= pc_q;
                pc_req_q    <= pc_q;
            end
            if (bus.redirect)
                pc_q <= bus.redirect_pc & ~32'd3;
            else if (issue)
                pc_q <= pc_q + 32'd4;
            if (bus.redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_post;
            end
        end
    end

    // NOTE: queue storage is deliberately not reset; entries are only visible
    // through has_head, so their power-up contents never reach decode.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.imem_data;
            pc4_mem[wr_ptr_q]   <= pc_req_q + 32'd4;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.id_valid  = has_head;
    assign bus.id_instr  = has_head ? instr_mem[rd_ptr_q] : '0;
    assign bus.id_pc4    = has_head ? pc4_mem[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, backpressure, redirects
// and PC wrap, with memory responses driven step by step.
module tb_fetch_stage;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fetch_if f_if ();
    fetch_if w_if ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (f_if)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (w_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        f_if.imem_valid = 1'b0; f_if.imem_data = '0; f_if.redirect = 1'b0;
        f_if.redirect_pc = '0;  f_if.id_ready = 1'b0;
        w_if.imem_valid = 1'b0; w_if.imem_data = '0; w_if.redirect = 1'b0;
        w_if.redirect_pc = '0;  w_if.id_ready = 1'b1;

        // Reset held 3 cycles while imem_valid toggles.
        for (int i = 0; i < 3; i++) begin
            f_if.imem_valid = i[0];
            f_if.imem_data  = 32'h1234_5678;
            tick();
            check("rst_req",   f_if.imem_req,  32'd0);
            check("rst_addr",  f_if.imem_addr, 32'd0);
            check("rst_valid", f_if.id_valid,  32'd0);
            check("rst_instr", f_if.id_instr,  32'd0);
            check("rst_pc4",   f_if.id_pc4,    32'd0);
        end
        reset = 1'b0;
        f_if.imem_valid = 1'b0;
        f_if.id_ready   = 1'b1;
        tick();
        check("first_req",   f_if.imem_req,  32'd1);
        check("first_addr",  f_if.imem_addr, 32'h0);
        check("wrap_req0",   w_if.imem_req,  32'd1);
        check("wrap_addr0",  w_if.imem_addr, 32'hFFFF_FFF8);

        // Straight line with a 1-cycle memory.
        f_if.imem_valid = 1'b1; f_if.imem_data = 32'hDEAD_0000;
        tick();
        check("sl_req1",   f_if.imem_req,  32'd1);
        check("sl_addr1",  f_if.imem_addr, 32'h4);
        check("sl_valid1", f_if.id_valid,  32'd1);
        check("sl_instr1", f_if.id_instr,  32'hDEAD_0000);
        check("sl_pc4_1",  f_if.id_pc4,    32'h4);
        f_if.imem_data = 32'hDEAD_0004;
        tick();
        check("sl_addr2",  f_if.imem_addr, 32'h8);
        check("sl_instr2", f_if.id_instr,  32'hDEAD_0004);
        check("sl_pc4_2",  f_if.id_pc4,    32'h8);
        f_if.imem_data = 32'hDEAD_0008;
        tick();
        check("sl_req3",   f_if.imem_req,  32'd1);
        check("sl_addr3",  f_if.imem_addr, 32'hC);
        check("sl_pc4_3",  f_if.id_pc4,    32'hC);

        // Fresh start for backpressure.
        reset = 1'b1; f_if.imem_valid = 1'b0;
        tick();
        reset = 1'b0; f_if.id_ready = 1'b0;
        tick();
        check("bp_req0",  f_if.imem_req,  32'd1);
        check("bp_addr0", f_if.imem_addr, 32'h0);
        f_if.imem_valid = 1'b1; f_if.imem_data = 32'hDEAD_0000;
        tick();
        check("bp_req1",  f_if.imem_req,  32'd1);
        check("bp_addr1", f_if.imem_addr, 32'h4);
        check("bp_pc4_1", f_if.id_pc4,    32'h4);
        f_if.imem_data = 32'hDEAD_0004;
        tick();
        check("bp_full_noreq", f_if.imem_req, 32'd0);
        check("bp_full_pc4",   f_if.id_pc4,   32'h4);
        f_if.imem_valid = 1'b0;
        tick();
        check("bp_hold_noreq", f_if.imem_req, 32'd0);
        check("bp_hold_valid", f_if.id_valid, 32'd1);
        check("bp_hold_instr", f_if.id_instr, 32'hDEAD_0000);
        f_if.id_ready = 1'b1;
        tick();
        check("bp_rel_req",   f_if.imem_req,  32'd1);
        check("bp_rel_addr",  f_if.imem_addr, 32'h8);
        check("bp_rel_pc4",   f_if.id_pc4,    32'h8);
        check("bp_rel_instr", f_if.id_instr,  32'hDEAD_0004);
        f_if.id_ready = 1'b0;
        tick();
        check("bp_one_req", f_if.imem_req, 32'd0);

        // Redirect while the request to 0x8 is outstanding (3-cycle memory).
        f_if.redirect = 1'b1; f_if.redirect_pc = 32'h40; f_if.id_ready = 1'b1;
        tick();
        check("rw_flush_valid", f_if.id_valid, 32'd0);
        check("rw_flush_pc4",   f_if.id_pc4,   32'd0);
        check("rw_noreq",       f_if.imem_req, 32'd0);
        f_if.redirect = 1'b0; f_if.imem_valid = 1'b1; f_if.imem_data = 32'hDEAD_0008;
        tick();
        check("rw_drop_noreq", f_if.imem_req, 32'd0);
        check("rw_drop_valid", f_if.id_valid, 32'd0);
        f_if.imem_valid = 1'b0;
        tick();
        check("rw_tgt_req",   f_if.imem_req,  32'd1);
        check("rw_tgt_addr",  f_if.imem_addr, 32'h40);
        check("rw_tgt_empty", f_if.id_valid,  32'd0);
        f_if.imem_valid = 1'b1; f_if.imem_data = 32'hDEAD_0040;
        tick();
        check("rw_valid", f_if.id_valid,  32'd1);
        check("rw_instr", f_if.id_instr,  32'hDEAD_0040);
        check("rw_pc4",   f_if.id_pc4,    32'h44);
        check("rw_next",  f_if.imem_addr, 32'h44);

        // Redirect coinciding with the response to 0x44.
        f_if.imem_data = 32'hDEAD_0044; f_if.redirect = 1'b1; f_if.redirect_pc = 32'h103;
        tick();
        check("rv_flush_valid", f_if.id_valid, 32'd0);
        check("rv_noreq",       f_if.imem_req, 32'd0);
        f_if.redirect = 1'b0; f_if.imem_valid = 1'b0;
        tick();
        check("rv_req",   f_if.imem_req,  32'd1);
        check("rv_addr",  f_if.imem_addr, 32'h100);
        check("rv_empty", f_if.id_valid,  32'd0);
        f_if.imem_valid = 1'b1; f_if.imem_data = 32'hDEAD_0100;
        tick();
        check("rv_instr", f_if.id_instr, 32'hDEAD_0100);
        check("rv_pc4",   f_if.id_pc4,   32'h104);
        f_if.imem_valid = 1'b0;

        // PC wrap on the second instance, waiting on FFFF_FFF8 since reset.
        w_if.imem_valid = 1'b1; w_if.imem_data = 32'hCAFE_0001;
        tick();
        check("wr_addr1",  w_if.imem_addr, 32'hFFFF_FFFC);
        check("wr_pc4_1",  w_if.id_pc4,    32'hFFFF_FFFC);
        check("wr_instr1", w_if.id_instr,  32'hCAFE_0001);
        w_if.imem_data = 32'hCAFE_0002;
        tick();
        check("wr_req2",   w_if.imem_req,  32'd1);
        check("wr_addr2",  w_if.imem_addr, 32'h0);
        check("wr_pc4_2",  w_if.id_pc4,    32'h0);
        check("wr_valid2", w_if.id_valid,  32'd1);
        w_if.imem_data = 32'hCAFE_0003;
        tick();
        check("wr_addr3", w_if.imem_addr, 32'h4);
        check("wr_pc4_3", w_if.id_pc4,    32'h4);
        w_if.imem_valid = 1'b0;

        // Reset mid-operation.
        reset = 1'b1;
        tick();
        check("mr_valid",  f_if.id_valid,  32'd0);
        check("mr_addr",   f_if.imem_addr, 32'd0);
        check("mr_wvalid", w_if.id_valid,  32'd0);
        check("mr_wreq",   w_if.imem_req,  32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
